logic_unit_arbiter: RTL and testbench
=====================================

# logic_unit_arbiter

Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters, e.g. the main execute path and the branch/address helper. Arbitrates round-robin, registers operands, computes the result, and holds it on a single response port until the consumer accepts it. Throughput is one operation per cycle under continuous back-pressure-free traffic. Each requester also has a saturating grant counter for performance monitoring.

## Interface
- WIDTH, 32, operand and result width.
- CNT_W, 16, width of each grant counter.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester i has an operation pending.
- req0_ready / req1_ready  out  1  requester i's operation is accepted this cycle.
- req0_op / req1_op  in  2  operation code: 00 AND, 01 OR, 10 XOR, 11 NOR.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- resp_valid  out  1  a result is held on the response port.
- resp_ready  in  1  the consumer accepts the result.
- resp_id  out  1  requester that owns the result.
- resp_data  out  WIDTH  result.
- resp_zero  out  1  set when resp_data is all zeros.
- grant_cnt0 / grant_cnt1  out  CNT_W  accepted operations per requester; saturate at all-ones.

## Operation
- States: IDLE (no result held) and RESP (result held, resp_valid=1).
- A slot is free when state==IDLE, or when state==RESP and resp_ready=1.
- Arbitration runs only while a slot is free:
  - If exactly one requester is valid, that requester is granted.
  - If both are valid, the requester selected by the priority pointer `prio` is granted.
- prio is updated only on a grant: prio <= ~granted_id.
- The granted requester's ready is asserted combinationally in the same cycle. The other ready is 0. Both readies are 0 when no slot is free.
- A transfer occurs when valid & ready. On the next edge:
  - state <= RESP.
  - resp_id, resp_data = op(a,b) and resp_zero are registered.
  - The granted requester's counter increments, unless it is already at all-ones.
- RESP with resp_ready=1 and no new grant: state <= IDLE and resp_valid drops.
- RESP with resp_ready=1 and a new grant in the same cycle: state stays RESP and the outputs load the new result (back-to-back).
- RESP with resp_ready=0: all response outputs hold stable and both readies are 0.
- Requesters must hold valid, op and operands stable until ready. Dropping valid before ready is permitted and does not count as a grant.

## Timing
- Reset values: state IDLE, prio 0, resp_valid 0, resp_id 0, resp_data 0, resp_zero 0, both counters 0. Readies are combinational and read 0 during reset.
- Reset asserted mid-operation clears everything on the next edge; a held result is discarded.
- Latency: accept in cycle N makes resp_valid=1 with data in cycle N+1.
- Sustained rate is 1 op/cycle while resp_ready=1.
- Simultaneous requests alternate strictly: 0,1,0,1… from reset.
- Counter saturation: at all-ones, further grants leave the value unchanged.
- No combinational path from resp_ready to resp_data. resp_ready does feed req*_ready combinationally; this path is documented and allowed.

## Structure
- Package logic_unit_pkg holds:
  - op codes: OP_AND, OP_OR, OP_XOR, OP_NOR as 2-bit localparams.
  - state encoding: ST_IDLE=0, ST_RESP=1.
  - default WIDTH.
- Sub-module logic_op_32 is the purely combinational WIDTH-bit op/a/b -> result cell.
  - Instantiated once, fed by the post-arbitration operand mux.
  - Its output is registered in the arbiter.
- The arbiter holds the FSM, priority pointer, response registers and counters, about 150–250 lines.

## Test plan
- Reset, then req0 op=00 a=0xF0F0_FFFF b=0x0FF0_00FF with resp_ready=1.
  - Required: req0_ready=1 in the same cycle.
  - Next cycle: resp_valid=1, resp_id=0, resp_data=0x00F0_00FF, resp_zero=0, grant_cnt0=1.
- Both requesters valid for 4 cycles with resp_ready=1 (req0 XOR 0xAAAA_AAAA^0xAAAA_AAAA; req1 NOR 0,0).
  - Required: grants 0,1,0,1.
  - Results alternate 0x0 (resp_zero=1) and 0xFFFF_FFFF.
  - Both counters end at 2.
- Back-pressure: a result is held and resp_ready=0 for 3 cycles while req1 is valid.
  - Required: both readies are 0 and resp_data is stable.
  - When resp_ready rises, req1 is granted in that cycle and the new result appears the next cycle.
- Back-to-back: 8 req0 ops with resp_ready held at 1.
  - Required: 8 consecutive resp_valid cycles with no bubble.
- Reset mid-operation: assert rst_n=0 while in RESP with resp_ready=0.
  - Required: resp_valid=0, counters 0 and prio 0 after the edge.
  - After reset releases, a simultaneous request grants req0 first.
- Saturation, with CNT_W=2: 5 grants to req1.
  - Required: grant_cnt1 sticks at 3.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the two-requester logic unit arbiter:
// operation codes, response FSM state encoding and default datapath width.
package logic_unit_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/logic_op_32.sv
// Purely combinational bitwise logic cell: result = op(a, b).
// The caller registers the output.
module logic_op_32
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      default: result_o = ~(a_i | b_i);
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between two requesters,
// with a registered single-entry response port and saturating grant counters.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero,

  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  state_e           state_q;
  logic             prio_q;
  logic             respId_q;
  logic [WIDTH-1:0] respData_q;
  logic             respZero_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  logic             slotFree;
  logic             grantValid;
  logic             grantId;
  logic [1:0]       opSel;
  logic [WIDTH-1:0] aSel;
  logic [WIDTH-1:0] bSel;
  logic [WIDTH-1:0] opResult;
  logic             respZero_d;
  logic [CNT_W-1:0] cnt0_d;
  logic [CNT_W-1:0] cnt1_d;

  // A slot opens when nothing is held or the held result leaves this cycle;
  // readies are forced low while reset is asserted.
  always_comb begin
    slotFree   = rst_n && ((state_q == ST_IDLE) || resp_ready);
    grantId    = 1'b0;
    if (req0_valid && req1_valid) begin
      grantId = prio_q;
    end else if (req1_valid) begin
      grantId = 1'b1;
    end
    grantValid = slotFree && (req0_valid || req1_valid);
  end

  assign req0_ready = grantValid && !grantId;
  assign req1_ready = grantValid &&  grantId;

  assign opSel = grantId ? req1_op : req0_op;
  assign aSel  = grantId ? req1_a  : req0_a;
  assign bSel  = grantId ? req1_b  : req0_b;

  logic_op_32 #(
    .WIDTH(WIDTH)
  ) u_logic_op (
    .op_i     (opSel),
    .a_i      (aSel),
    .b_i      (bSel),
    .result_o (opResult)
  );

  assign respZero_d = (opResult == '0);
  assign cnt0_d     = (cnt0_q == '1) ? cnt0_q : cnt0_q + CNT_W'(1);
  assign cnt1_d     = (cnt1_q == '1) ? cnt1_q : cnt1_q + CNT_W'(1);

  // A grant always (re)loads the response registers, which is what makes
  // back-to-back transfers bubble-free; without one, a consumed result idles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      prio_q     <= 1'b0;
      respId_q   <= 1'b0;
      respData_q <= '0;
      respZero_q <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else if (grantValid) begin
      state_q    <= ST_RESP;
      prio_q     <= ~grantId;
      respId_q   <= grantId;
      respData_q <= opResult;
      respZero_q <= respZero_d;
      if (grantId) begin
        cnt1_q <= cnt1_d;
      end else begin
        cnt0_q <= cnt0_d;
      end
    end else if ((state_q == ST_RESP) && resp_ready) begin
      state_q <= ST_IDLE;
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_id    = respId_q;
  assign resp_data  = respData_q;
  assign resp_zero  = respZero_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: a default instance plus a CNT_W=2
// instance on the same stimulus for counter saturation.
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0Valid, req1Valid, respReady;
  logic [1:0]  req0Op, req1Op;
  logic [31:0] req0A, req0B, req1A, req1B;

  logic        req0Ready, req1Ready, respValid, respId, respZero;
  logic [31:0] respData;
  logic [15:0] cnt0, cnt1;

  logic        sReq0Ready, sReq1Ready, sRespValid, sRespId, sRespZero;
  logic [31:0] sRespData;
  logic [1:0]  sCnt0, sCnt1;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0Valid), .req0_ready(req0Ready), .req0_op(req0Op), .req0_a(req0A), .req0_b(req0B),
    .req1_valid(req1Valid), .req1_ready(req1Ready), .req1_op(req1Op), .req1_a(req1A), .req1_b(req1B),
    .resp_valid(respValid), .resp_ready(respReady), .resp_id(respId), .resp_data(respData),
    .resp_zero(respZero), .grant_cnt0(cnt0), .grant_cnt1(cnt1)
  );

  logic_unit_arbiter #(.CNT_W(2)) dutSmall (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0Valid), .req0_ready(sReq0Ready), .req0_op(req0Op), .req0_a(req0A), .req0_b(req0B),
    .req1_valid(req1Valid), .req1_ready(sReq1Ready), .req1_op(req1Op), .req1_a(req1A), .req1_b(req1B),
    .resp_valid(sRespValid), .resp_ready(respReady), .resp_id(sRespId), .resp_data(sRespData),
    .resp_zero(sRespZero), .grant_cnt0(sCnt0), .grant_cnt1(sCnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [1:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic v1, input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] b1);
    req0Valid = v0; req0Op = op0; req0A = a0; req0B = b0;
    req1Valid = v1; req1Op = op1; req1A = a1; req1B = b1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; respReady = 1'b1;
    applyStimulus(1'b1, 2'b00, 32'h1, 32'h1, 1'b1, 2'b00, 32'h1, 32'h1);
    tick(); tick();
    tests++; if (respValid !== 1'b0) begin failed++; $display("[TB] FAIL reset.resp_valid got %b want 0", respValid); end
    tests++; if (respId !== 1'b0) begin failed++; $display("[TB] FAIL reset.resp_id got %b want 0", respId); end
    tests++; if (respData !== 32'h0) begin failed++; $display("[TB] FAIL reset.resp_data got %h want 0", respData); end
    tests++; if (respZero !== 1'b0) begin failed++; $display("[TB] FAIL reset.resp_zero got %b want 0", respZero); end
    tests++; if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin failed++; $display("[TB] FAIL reset.counters got %0d/%0d want 0/0", cnt0, cnt1); end
    tests++; if (req0Ready !== 1'b0 || req1Ready !== 1'b0) begin failed++; $display("[TB] FAIL reset.readies got %b%b want 00", req0Ready, req1Ready); end
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_single_and();
    respReady = 1'b1;
    applyStimulus(1'b1, 2'b00, 32'hF0F0_FFFF, 32'h0FF0_00FF, 1'b0, 2'b00, 32'h0, 32'h0);
    #1;
    tests++; if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin failed++; $display("[TB] FAIL single.readies got %b%b want 10", req0Ready, req1Ready); end
    tick();
    req0Valid = 1'b0;
    tests++; if (respValid !== 1'b1) begin failed++; $display("[TB] FAIL single.resp_valid got %b want 1", respValid); end
    tests++; if (respId !== 1'b0) begin failed++; $display("[TB] FAIL single.resp_id got %b want 0", respId); end
    tests++; if (respData !== 32'h00F0_00FF) begin failed++; $display("[TB] FAIL single.resp_data got %h want 00f000ff", respData); end
    tests++; if (respZero !== 1'b0) begin failed++; $display("[TB] FAIL single.resp_zero got %b want 0", respZero); end
    tests++; if (cnt0 !== 16'd1) begin failed++; $display("[TB] FAIL single.grant_cnt0 got %0d want 1", cnt0); end
    tick();
    tests++; if (respValid !== 1'b0) begin failed++; $display("[TB] FAIL single.drain got %b want 0", respValid); end
  endtask

  task automatic test_round_robin();
    logic        expId;
    logic [31:0] expData;
    doReset();
    respReady = 1'b1;
    applyStimulus(1'b1, 2'b10, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b1, 2'b11, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      expId   = (k % 2 == 1);
      expData = expId ? 32'hFFFF_FFFF : 32'h0;
      #1;
      tests++; if (req0Ready !== !expId || req1Ready !== expId) begin failed++; $display("[TB] FAIL rr.readies[%0d] got %b%b want %b%b", k, req0Ready, req1Ready, !expId, expId); end
      tick();
      tests++; if (respId !== expId || respData !== expData || respZero !== !expId) begin
        failed++; $display("[TB] FAIL rr.resp[%0d] got id=%b data=%h zero=%b want id=%b data=%h zero=%b", k, respId, respData, respZero, expId, expData, !expId);
      end
    end
    req0Valid = 1'b0; req1Valid = 1'b0;
    tests++; if (cnt0 !== 16'd2 || cnt1 !== 16'd2) begin failed++; $display("[TB] FAIL rr.counters got %0d/%0d want 2/2", cnt0, cnt1); end
  endtask

  task automatic test_back_pressure();
    respReady = 1'b0;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 32'h1234_5678, 32'hFFFF_0000);
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (req0Ready !== 1'b0 || req1Ready !== 1'b0) begin failed++; $display("[TB] FAIL bp.readies[%0d] got %b%b want 00", k, req0Ready, req1Ready); end
      tests++; if (respValid !== 1'b1 || respId !== 1'b1 || respData !== 32'hFFFF_FFFF) begin
        failed++; $display("[TB] FAIL bp.hold[%0d] got v=%b id=%b data=%h want v=1 id=1 data=ffffffff", k, respValid, respId, respData);
      end
      tick();
    end
    respReady = 1'b1;
    #1;
    tests++; if (req1Ready !== 1'b1 || req0Ready !== 1'b0) begin failed++; $display("[TB] FAIL bp.release got %b%b want 01", req0Ready, req1Ready); end
    tick();
    req1Valid = 1'b0;
    tests++; if (respValid !== 1'b1 || respId !== 1'b1 || respData !== 32'h1234_0000 || respZero !== 1'b0) begin
      failed++; $display("[TB] FAIL bp.newresult got v=%b id=%b data=%h zero=%b want v=1 id=1 data=12340000 zero=0", respValid, respId, respData, respZero);
    end
    tests++; if (cnt1 !== 16'd3) begin failed++; $display("[TB] FAIL bp.grant_cnt1 got %0d want 3", cnt1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expTable [4];
    expTable[0] = 32'h000F_000F;
    expTable[1] = 32'h0FFF_0FFF;
    expTable[2] = 32'h0FF0_0FF0;
    expTable[3] = 32'hF000_F000;
    respReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 2'(i % 4), 32'h0F0F_0F0F, 32'h00FF_00FF, 1'b0, 2'b00, 32'h0, 32'h0);
      #1;
      tests++; if (req0Ready !== 1'b1) begin failed++; $display("[TB] FAIL b2b.ready[%0d] got %b want 1", i, req0Ready); end
      tick();
      tests++; if (respValid !== 1'b1 || respId !== 1'b0 || respData !== expTable[i % 4]) begin
        failed++; $display("[TB] FAIL b2b.resp[%0d] got v=%b id=%b data=%h want v=1 id=0 data=%h", i, respValid, respId, respData, expTable[i % 4]);
      end
    end
    req0Valid = 1'b0;
    tests++; if (cnt0 !== 16'd10) begin failed++; $display("[TB] FAIL b2b.grant_cnt0 got %0d want 10", cnt0); end
  endtask

  task automatic test_reset_mid_op();
    respReady = 1'b0;
    tick();
    rst_n = 1'b0;
    applyStimulus(1'b1, 2'b11, 32'h0F0F_0F0F, 32'h00FF_00FF, 1'b1, 2'b01, 32'h0, 32'h0);
    #1;
    tests++; if (req0Ready !== 1'b0 || req1Ready !== 1'b0) begin failed++; $display("[TB] FAIL rstmid.readies got %b%b want 00", req0Ready, req1Ready); end
    tick();
    tests++; if (respValid !== 1'b0 || respData !== 32'h0) begin failed++; $display("[TB] FAIL rstmid.resp got v=%b data=%h want v=0 data=0", respValid, respData); end
    tests++; if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin failed++; $display("[TB] FAIL rstmid.counters got %0d/%0d want 0/0", cnt0, cnt1); end
    rst_n = 1'b1;
    respReady = 1'b1;
    #1;
    tests++; if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin failed++; $display("[TB] FAIL rstmid.prio got %b%b want 10", req0Ready, req1Ready); end
    tick();
    req0Valid = 1'b0; req1Valid = 1'b0;
    tests++; if (respId !== 1'b0 || respData !== 32'hF000_F000) begin failed++; $display("[TB] FAIL rstmid.first got id=%b data=%h want id=0 data=f000f000", respId, respData); end
  endtask

  task automatic test_saturation();
    logic [1:0] expSmall;
    respReady = 1'b1;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 2'b01, 32'h0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      expSmall = (k < 3) ? 2'(k + 1) : 2'd3;
      #1;
      tests++; if (req1Ready !== 1'b1 || sReq1Ready !== 1'b1 || sReq0Ready !== 1'b0) begin
        failed++; $display("[TB] FAIL sat.ready[%0d] got %b/%b/%b want 1/1/0", k, req1Ready, sReq1Ready, sReq0Ready);
      end
      tick();
      tests++; if (sCnt1 !== expSmall) begin failed++; $display("[TB] FAIL sat.small_cnt1[%0d] got %0d want %0d", k, sCnt1, expSmall); end
      tests++; if (cnt1 !== 16'(k + 1)) begin failed++; $display("[TB] FAIL sat.cnt1[%0d] got %0d want %0d", k, cnt1, k + 1); end
      tests++; if (sRespValid !== 1'b1 || sRespId !== 1'b1 || sRespData !== 32'h0 || sRespZero !== 1'b1) begin
        failed++; $display("[TB] FAIL sat.small_resp[%0d] got v=%b id=%b data=%h zero=%b want v=1 id=1 data=0 zero=1", k, sRespValid, sRespId, sRespData, sRespZero);
      end
    end
    req1Valid = 1'b0;
    tests++; if (sCnt0 !== 2'd1) begin failed++; $display("[TB] FAIL sat.small_cnt0 got %0d want 1", sCnt0); end
  endtask

  initial begin
    test_reset();
    test_single_and();
    test_round_robin();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_op();
    test_saturation();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
